// File: rtl/wor_bus_pkg.sv
// Shared types for the wired-bus round-robin scheduler.
package wor_bus_pkg;

  localparam int unsigned BUS_W = 16;

  typedef logic [0:1][1:2][1:4] bus_t;

  typedef enum logic [1:0] {IDLE, OWN, GAP} sched_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set request strictly after rr_ptr, wrapping,
// so the previous winner always ends up with the lowest priority.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);

  int unsigned idx;

  // Scan from farthest to nearest so the nearest set bit is written last.
  always_comb begin
    winner = '0;
    idx    = 0;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req[idx]) winner = IDX_W'(idx);
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/wor_bus_sched.sv
// Round-robin owner of a shared 16-bit wired bus with a hold limit and a
// programmable turnaround gap after each release.
module wor_bus_sched
  import wor_bus_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned MAX_HOLD   = 4,
  parameter int unsigned TURNAROUND = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  bus_t [NUM_REQ-1:0]         req_data,
  output logic [NUM_REQ-1:0]         gnt,
  output bus_t                       bus_out,
  output logic                       bus_valid,
  output logic [$clog2(NUM_REQ)-1:0] bus_owner,
  output logic                       preempt
);

  localparam int unsigned IDX_W    = $clog2(NUM_REQ);
  localparam logic [3:0]  HOLD_MAX = 4'(MAX_HOLD);

  sched_state_t       state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  bus_t               bus_q, bus_d;
  logic               valid_q, valid_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [3:0]         hold_q, hold_d;
  logic [1:0]         gap_q, gap_d;
  logic               preempt_q, preempt_d;

  logic [IDX_W-1:0]   win;
  logic               any_req;
  logic               arb;
  logic               rel;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .winner (win),
    .any_req(any_req)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      bus_q     <= '0;
      valid_q   <= 1'b0;
      rr_ptr_q  <= '0;
      hold_q    <= '0;
      gap_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      bus_q     <= bus_d;
      valid_q   <= valid_d;
      rr_ptr_q  <= rr_ptr_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
      preempt_q <= preempt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    bus_d     = bus_q;
    valid_d   = valid_q;
    rr_ptr_d  = rr_ptr_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    preempt_d = 1'b0;
    arb       = 1'b0;
    rel       = 1'b0;

    unique case (state_q)
      IDLE: arb = 1'b1;
      OWN: begin
        // rr_ptr_q always names the current owner while in OWN.
        if (!req[rr_ptr_q]) begin
          rel = 1'b1;
        end else if (hold_q == HOLD_MAX) begin
          rel       = 1'b1;
          preempt_d = 1'b1;
        end else begin
          bus_d  = req_data[rr_ptr_q];
          hold_d = hold_q + 4'd1;
        end
      end
      GAP: begin
        gap_d = gap_q - 2'd1;
        if (gap_q == 2'd1) arb = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (rel) begin
      gnt_d   = '0;
      valid_d = 1'b0;
      bus_d   = '0;
      if (TURNAROUND > 0) begin
        state_d = GAP;
        gap_d   = 2'(TURNAROUND);
      end else begin
        state_d = IDLE;
        arb     = 1'b1;
      end
    end

    // A fresh grant overrides any release clearing done above.
    if (arb) begin
      if (any_req) begin
        state_d    = OWN;
        gnt_d      = '0;
        gnt_d[win] = 1'b1;
        rr_ptr_d   = win;
        bus_d      = req_data[win];
        valid_d    = 1'b1;
        hold_d     = 4'd1;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    gnt       = gnt_q;
    bus_out   = bus_q;
    bus_valid = valid_q;
    bus_owner = rr_ptr_q;
    preempt   = preempt_q;
  end

endmodule

// File: tb/tb_wor_bus_sched.sv
// Bench for wor_bus_sched: directed table, corner sequences and random traffic
// checked against an abstract ownership model for TURNAROUND=1 and TURNAROUND=0.
module tb_wor_bus_sched;
  import wor_bus_pkg::*;

  localparam int MAXH = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  bus_t [3:0] req_data;

  logic [3:0] gnt1, gnt0;
  bus_t       bus1, bus0;
  logic       valid1, valid0;
  logic [1:0] owner1, owner0;
  logic       pre1, pre0;

  wor_bus_sched #(.NUM_REQ(4), .MAX_HOLD(MAXH), .TURNAROUND(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt1),
    .bus_out(bus1), .bus_valid(valid1), .bus_owner(owner1), .preempt(pre1)
  );

  wor_bus_sched #(.NUM_REQ(4), .MAX_HOLD(MAXH), .TURNAROUND(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt0),
    .bus_out(bus0), .bus_valid(valid0), .bus_owner(owner0), .preempt(pre0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // owner = -1 means nobody holds the bus; gap counts idle edges still owed.
  typedef struct {
    int          owner;
    int          last;
    int          beats;
    int          gap;
    logic [15:0] bus;
    logic        pre;
  } mdl_t;

  mdl_t m1, m0;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic        valid;
    logic [1:0]  owner;
    logic        pre;
    logic [15:0] bus;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void mreset(inout mdl_t m);
    m.owner = -1;
    m.last  = 0;
    m.beats = 0;
    m.gap   = 0;
    m.bus   = '0;
    m.pre   = 1'b0;
  endfunction

  function automatic void mstep(input int ta, input logic [3:0] r,
                                input logic [3:0][15:0] d, inout mdl_t m);
    bit arb;
    bit found;
    int c;
    arb   = 0;
    found = 0;
    m.pre = 1'b0;
    if (m.owner >= 0) begin
      if (!r[m.owner] || m.beats == MAXH) begin
        m.pre   = r[m.owner];
        m.owner = -1;
        m.bus   = '0;
        if (ta > 0) m.gap = ta;
        else arb = 1;
      end else begin
        m.beats++;
        m.bus = d[m.owner];
      end
    end else if (m.gap > 0) begin
      m.gap--;
      arb = (m.gap == 0);
    end else begin
      arb = 1;
    end
    if (arb && r != 4'b0) begin
      for (int k = 1; k <= 4; k++) begin
        c = (m.last + k) % 4;
        if (!found && r[c]) begin
          found   = 1;
          m.owner = c;
          m.last  = c;
          m.beats = 1;
          m.bus   = d[c];
        end
      end
    end
  endfunction

  task automatic cmp(input string nm, input logic [3:0] g, input logic v, input logic [1:0] o,
                     input logic p, input logic [15:0] b, input mdl_t m);
    logic [3:0] eg;
    eg = (m.owner >= 0) ? 4'(4'b1 << m.owner) : 4'b0;
    chk(nm, {40'd0, g, v, o, p, b}, {40'd0, eg, (m.owner >= 0), 2'(m.last), m.pre, m.bus});
    chk({nm, "_inv"}, {63'd0, v}, {63'd0, |g});
  endtask

  task automatic tick();
    @(posedge clk);
    mstep(1, req, req_data, m1);
    mstep(0, req, req_data, m0);
    @(negedge clk);
    cmp("dut", gnt1, valid1, owner1, pre1, bus1, m1);
    cmp("dut0", gnt0, valid0, owner0, pre0, bus0, m0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mreset(m1);
    mreset(m0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    int np;
    logic [15:0] prev_bus;

    tbl[0]  = '{4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0, 16'hA5C3};
    tbl[1]  = '{4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0, 16'hA5C3};
    tbl[2]  = '{4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0, 16'h0000};
    tbl[3]  = '{4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0, 16'h0000};
    tbl[4]  = '{4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0, 16'h2222};
    tbl[5]  = '{4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0, 16'h2222};
    tbl[6]  = '{4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0, 16'h2222};
    tbl[7]  = '{4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0, 16'h2222};
    tbl[8]  = '{4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0, 16'h0000};
    tbl[9]  = '{4'b0000, 4'b0000, 1'b0, 2'd1, 1'b0, 16'h0000};
    tbl[10] = '{4'b1111, 4'b0100, 1'b1, 2'd2, 1'b0, 16'hA5C3};
    tbl[11] = '{4'b1111, 4'b0100, 1'b1, 2'd2, 1'b0, 16'hA5C3};
    tbl[12] = '{4'b1111, 4'b0100, 1'b1, 2'd2, 1'b0, 16'hA5C3};
    tbl[13] = '{4'b1111, 4'b0100, 1'b1, 2'd2, 1'b0, 16'hA5C3};
    tbl[14] = '{4'b1111, 4'b0000, 1'b0, 2'd2, 1'b1, 16'h0000};
    tbl[15] = '{4'b1111, 4'b1000, 1'b1, 2'd3, 1'b0, 16'h3333};

    rst_n    = 1'b1;
    req      = '0;
    req_data = '0;
    mreset(m1);
    mreset(m0);
    #1 rst_n = 1'b0;
    #1;
    cmp("reset_dut", gnt1, valid1, owner1, pre1, bus1, m1);
    cmp("reset_dut0", gnt0, valid0, owner0, pre0, bus0, m0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    req_data[0] = 16'h1111;
    req_data[1] = 16'h2222;
    req_data[2] = 16'hA5C3;
    req_data[3] = 16'h3333;
    for (int i = 0; i < 16; i++) begin
      req = tbl[i].req;
      tick();
      chk($sformatf("tbl%0d", i), {40'd0, gnt1, valid1, owner1, pre1, bus1},
          {40'd0, tbl[i].gnt, tbl[i].valid, tbl[i].owner, tbl[i].pre, tbl[i].bus});
    end

    // Sole requester: expect 4 valid, 1 gap, 4 valid, 1 gap, 2 valid.
    req = 4'b0000;
    repeat (3) tick();
    req = 4'b0001;
    nv  = 0;
    np  = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      nv += int'(valid1);
      np += int'(pre1);
    end
    chk("sole_valid", 64'(nv), 64'd10);
    chk("sole_preempt", 64'(np), 64'd2);

    // Zero turnaround: owner 0 hands straight over to owner 1.
    req = 4'b0000;
    do_reset();
    req_data[0] = 16'hDEAD;
    req_data[1] = 16'hBEEF;
    req = 4'b0001;
    tick();
    chk("b2b_first", {40'd0, gnt0, valid0, 3'd0, bus0}, {40'd0, 4'b0001, 1'b1, 3'd0, 16'hDEAD});
    req = 4'b0011;
    tick();
    prev_bus = bus0;
    req = 4'b0010;
    tick();
    chk("b2b_handover", {24'd0, gnt0, valid0, owner0, 1'b0, prev_bus, bus1 == 16'h0 ? bus0 : bus0},
        {24'd0, 4'b0010, 1'b1, 2'd1, 1'b0, 16'hDEAD, 16'hBEEF});

    // Asynchronous reset in the middle of a grant.
    req = 4'b0100;
    req_data[2] = 16'($urandom);
    tick();
    tick();
    chk("pre_rst_own", {63'd0, valid1}, 64'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst", {32'd0, gnt1, gnt0, valid1, valid0, 6'd0, bus1 | bus0}, 64'd0);
    mreset(m1);
    mreset(m0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1111;
    tick();
    chk("rst_first_grant", {56'd0, gnt1, gnt0}, {56'd0, 4'b0010, 4'b0010});

    // Random traffic; requests tend to persist so hold limits are reached.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      for (int j = 0; j < 4; j++) req_data[j] = 16'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
